// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR fault monitor.
//   lane_state_e : per-lane health state
//   LANE_A/B/C   : bit positions of each replica in the fault vector
//   RUN_W        : width of the consecutive-disagreement run counter
package tmr_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } lane_state_e;

    localparam int LANE_A = 0;
    localparam int LANE_B = 1;
    localparam int LANE_C = 2;

    localparam int RUN_W = 4;

endpackage

// File: rtl/tmr_lane_tracker.sv
// Health tracker for one replica lane.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_OK      | lane agreed with the majority on its last valid sample
// ST_SUSPECT | lane has disagreed on run_q consecutive valid samples
// ST_FAULT   | threshold reached; sticky until clr_i or reset
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear of state, run and mismatch counter
//   valid_i     a sample is present this cycle
//   dis_i       this lane disagrees with the majority (already gated by valid)
//   fault_o     registered fault flag
//   fault_d_o   next-state fault flag (lets the top register multi-fault in step)
//   mis_cnt_o   saturating count of all disagreements
module tmr_lane_tracker
    import tmr_pkg::*;
#(
    parameter int FAULT_THRESH = 3,   // 1..15
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic             dis_i,
    output logic             fault_o,
    output logic             fault_d_o,
    output logic [CNT_W-1:0] mis_cnt_o
);

    localparam logic [RUN_W-1:0] THRESH  = RUN_W'(FAULT_THRESH);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    lane_state_e      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] run_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign run_inc = run_q + RUN_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OK;
            run_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (clr_i) begin
            state_d = ST_OK;
            run_d   = '0;
        end else begin
            case (state_q)
                ST_OK: begin
                    if (dis_i) begin
                        run_d   = RUN_ONE;
                        state_d = (THRESH == RUN_ONE) ? ST_FAULT : ST_SUSPECT;
                    end
                end
                ST_SUSPECT: begin
                    if (dis_i) begin
                        run_d = run_inc;
                        if (run_inc == THRESH) begin
                            state_d = ST_FAULT;
                        end
                    end else if (valid_i) begin
                        state_d = ST_OK;
                        run_d   = '0;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_OK;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Counts in every state, FAULT included; clr wins over the sample.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (dis_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign fault_o   = (state_q == ST_FAULT);
    assign fault_d_o = (state_d == ST_FAULT);
    assign mis_cnt_o = cnt_q;

endmodule

// File: rtl/tmr_fault_monitor.sv
// Triple-modular-redundancy voter with per-lane fault monitoring.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, A, B, C   replica sample and its valid strobe
//   clr                 fault acknowledge (clears flags, runs and counters)
//   X, out_valid        registered raw majority, one cycle after the sample
//   fault[2:0]          sticky lane fault flags (bit0=A, bit1=B, bit2=C)
//   multi_fault         two or more lanes faulted
//   mis_cnt_a/b/c       saturating per-lane mismatch counters
module tmr_fault_monitor
    import tmr_pkg::*;
#(
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             clr,
    output logic             X,
    output logic             out_valid,
    output logic [2:0]       fault,
    output logic             multi_fault,
    output logic [CNT_W-1:0] mis_cnt_a,
    output logic [CNT_W-1:0] mis_cnt_b,
    output logic [CNT_W-1:0] mis_cnt_c
);

    logic [2:0]       lanes;
    logic             maj;
    logic [2:0]       dis;
    logic [2:0]       fault_d;
    logic             multi_d;
    logic [CNT_W-1:0] cnt [3];

    logic x_q, out_valid_q, multi_fault_q;

    assign lanes = {C, B, A};
    assign maj   = (A & B) | (A & C) | (B & C);

    for (genvar i = 0; i < 3; i++) begin : g_lane
        assign dis[i] = in_valid & (lanes[i] != maj);

        tmr_lane_tracker #(
            .FAULT_THRESH(FAULT_THRESH),
            .CNT_W       (CNT_W)
        ) u_trk (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (clr),
            .valid_i  (in_valid),
            .dis_i    (dis[i]),
            .fault_o  (fault[i]),
            .fault_d_o(fault_d[i]),
            .mis_cnt_o(cnt[i])
        );
    end

    // Built from next-state flags so the alarm rises with the second fault bit.
    assign multi_d = (fault_d[0] & fault_d[1]) | (fault_d[0] & fault_d[2]) |
                     (fault_d[1] & fault_d[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= 1'b0;
            out_valid_q   <= 1'b0;
            multi_fault_q <= 1'b0;
        end else begin
            out_valid_q   <= in_valid;
            multi_fault_q <= multi_d;
            if (in_valid) begin
                x_q <= maj;
            end
        end
    end

    assign X           = x_q;
    assign out_valid   = out_valid_q;
    assign multi_fault = multi_fault_q;
    assign mis_cnt_a   = cnt[LANE_A];
    assign mis_cnt_b   = cnt[LANE_B];
    assign mis_cnt_c   = cnt[LANE_C];

endmodule

// File: tb/tb_tmr_fault_monitor.sv
module tb_tmr_fault_monitor;

    localparam int THRESH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, A = 1'b0, B = 1'b0, C = 1'b0, clr = 1'b0;

    logic       X, out_valid, multi_fault;
    logic [2:0] fault;
    logic [7:0] mis_cnt_a, mis_cnt_b, mis_cnt_c;

    logic       X2, out_valid2, multi_fault2;
    logic [2:0] fault2;
    logic [1:0] mis2_a, mis2_b, mis2_c;

    tmr_fault_monitor #(.FAULT_THRESH(THRESH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .C(C), .clr(clr),
        .X(X), .out_valid(out_valid), .fault(fault), .multi_fault(multi_fault),
        .mis_cnt_a(mis_cnt_a), .mis_cnt_b(mis_cnt_b), .mis_cnt_c(mis_cnt_c)
    );

    tmr_fault_monitor #(.FAULT_THRESH(THRESH), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .C(C), .clr(clr),
        .X(X2), .out_valid(out_valid2), .fault(fault2), .multi_fault(multi_fault2),
        .mis_cnt_a(mis2_a), .mis_cnt_b(mis2_b), .mis_cnt_c(mis2_c)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: consecutive-disagreement counts and sticky flags.
    int run_m [3];
    bit flt_m [3];
    int c8_m  [3];
    int c2_m  [3];

    typedef struct packed {
        logic       x;
        logic [2:0] f;
        logic       m;
        logic [23:0] c8;
        logic [5:0]  c2;
    } exp_t;

    exp_t exp_q [$];

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            run_m[i] = 0; flt_m[i] = 0; c8_m[i] = 0; c2_m[i] = 0;
        end
    endfunction

    function automatic void model_step(input bit v, input bit a, input bit b, input bit c, input bit cl);
        bit   ln [3];
        bit   mj;
        int   nf;
        exp_t e;
        ln[0] = a; ln[1] = b; ln[2] = c;
        mj = (int'(a) + int'(b) + int'(c)) >= 2;
        if (cl) begin
            model_reset();
        end else if (v) begin
            for (int i = 0; i < 3; i++) begin
                if (ln[i] != mj) begin
                    if (c8_m[i] < 255) c8_m[i]++;
                    if (c2_m[i] < 3) c2_m[i]++;
                    if (!flt_m[i]) begin
                        run_m[i]++;
                        if (run_m[i] >= THRESH) flt_m[i] = 1;
                    end
                end else if (!flt_m[i]) begin
                    run_m[i] = 0;
                end
            end
        end
        if (v) begin
            nf = 0;
            for (int i = 0; i < 3; i++) nf += int'(flt_m[i]);
            e.x  = mj;
            e.f  = {flt_m[2], flt_m[1], flt_m[0]};
            e.m  = (nf >= 2);
            e.c8 = {8'(c8_m[2]), 8'(c8_m[1]), 8'(c8_m[0])};
            e.c2 = {2'(c2_m[2]), 2'(c2_m[1]), 2'(c2_m[0])};
            exp_q.push_back(e);
        end
    endfunction

    // Inputs change 1ns after the rising edge and are captured at the next one.
    task automatic step(input bit v, input bit a, input bit b, input bit c, input bit cl);
        in_valid = v; A = a; B = b; C = c; clr = cl;
        model_step(v, a, b, c, cl);
        @(posedge clk);
        #1;
        in_valid = 0; clr = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_X"}, X, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_multi"}, multi_fault, 0);
        check({tag, "_cnt_a"}, mis_cnt_a, 0);
        check({tag, "_cnt_b"}, mis_cnt_b, 0);
        check({tag, "_cnt_c"}, mis_cnt_c, 0);
        check({tag, "_cnt2_c"}, mis2_c, 0);
    endtask

    // Monitor: pops one expectation per presented output.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("X", X, e.x);
                check("fault", fault, e.f);
                check("multi_fault", multi_fault, e.m);
                check("mis_cnt_a", mis_cnt_a, e.c8[7:0]);
                check("mis_cnt_b", mis_cnt_b, e.c8[15:8]);
                check("mis_cnt_c", mis_cnt_c, e.c8[23:16]);
                check("mis2_a", mis2_a, e.c2[1:0]);
                check("mis2_b", mis2_b, e.c2[3:2]);
                check("mis2_c", mis2_c, e.c2[5:4]);
                check("fault_w2", fault2, e.f);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Plain voting
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        step(0, 1, 1, 1, 0);

        // Lane A faults on the third consecutive disagreement, keeps counting
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);

        // Lane B: 2 dis, agree, 2 dis, then a third dis faults it (multi with A)
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1);

        // A then C fault, then clr with a simultaneous C-disagreeing sample
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);

        // Saturation of the narrow counter
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // Reset while lane A is SUSPECT with run=2
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 0;
        in_valid = 1; A = 1; B = 0; C = 0;
        #1;
        check_reset_values("midreset");
        model_reset();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit v, cl, base;
            bit ln [3];
            int r;
            v    = ($urandom_range(0, 9) < 8);
            cl   = ($urandom_range(0, 29) == 0);
            base = 1'($urandom_range(0, 1));
            r    = $urandom_range(0, 3);
            for (int i = 0; i < 3; i++) ln[i] = base;
            if (r > 0) ln[r-1] = ~base;
            step(v, ln[0], ln[1], ln[2], cl);
        end

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
